// File: rtl/job_completion_ring.sv
`default_nettype none
// ============================================================================
// job_completion_ring: per-channel completion records written to host rings
// through a single-beat AXI4 write master, with bresp retry and drop report.
// Revision 1.0
// ============================================================================
module job_completion_ring #(
   parameter int ID_WIDTH     = 1,
   parameter int AWUSER_WIDTH = 9,
   parameter int DATA_WIDTH   = 1024,
   parameter int ADDR_WIDTH   = 64,
   parameter int CH_AW        = 9,
   parameter int RET_WIDTH    = 32,
   parameter int FIFO_DEPTH   = 16,
   parameter int MAX_RETRY    = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    cfg_we,
   input  logic [CH_AW-1:0]        cfg_ch,
   input  logic [1:0]              cfg_sel,
   input  logic [31:0]             cfg_data,
   input  logic                    cmpl_valid_i,
   output logic                    cmpl_ready_o,
   input  logic [CH_AW-1:0]        cmpl_ch_i,
   input  logic [RET_WIDTH-1:0]    cmpl_code_i,
   output logic [ID_WIDTH-1:0]     m_axi_awid,
   output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic [7:0]              m_axi_awlen,
   output logic [2:0]              m_axi_awsize,
   output logic [1:0]              m_axi_awburst,
   output logic [3:0]              m_axi_awcache,
   output logic                    m_axi_awlock,
   output logic [2:0]              m_axi_awprot,
   output logic [3:0]              m_axi_awqos,
   output logic [AWUSER_WIDTH-1:0] m_axi_awuser,
   output logic                    m_axi_awvalid,
   input  logic                    m_axi_awready,
   output logic [DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
   output logic                    m_axi_wlast,
   output logic                    m_axi_wvalid,
   input  logic                    m_axi_wready,
   output logic                    m_axi_bready,
   input  logic [1:0]              m_axi_bresp,
   input  logic                    m_axi_bvalid,
   output logic                    err_valid_o,
   output logic [CH_AW-1:0]        err_ch_o
);
   localparam int NUM_CH     = 2**CH_AW;
   localparam int BEAT_SHIFT = $clog2(DATA_WIDTH/8);
   localparam int FIFO_AW    = $clog2(FIFO_DEPTH);
   localparam int RTY_W      = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT_B = 2'd2, UPDATE = 2'd3} state_t;
   state_t state;

   logic [63:0] base_tbl  [NUM_CH];
   logic [15:0] size_tbl  [NUM_CH];
   logic [15:0] off_tbl   [NUM_CH];
   logic        phase_tbl [NUM_CH];

   logic [CH_AW+RET_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
   logic [FIFO_AW-1:0]         wr_ptr, rd_ptr;
   logic [FIFO_AW:0]           count;
   logic                       push, pop;
   logic [CH_AW-1:0]           head_ch;
   logic [RET_WIDTH-1:0]       head_code;

   logic [CH_AW-1:0]      rec_ch;
   logic [RET_WIDTH-1:0]  rec_code;
   logic                  rec_phase;
   logic [ADDR_WIDTH-1:0] rec_addr;
   logic [RTY_W-1:0]      retry;
   logic [63:0]           slot_addr;
   logic                  aw_done, w_done, cfg_hit_rec;

   assign cmpl_ready_o       = (count != (FIFO_AW+1)'(FIFO_DEPTH));
   assign push               = cmpl_valid_i && cmpl_ready_o;
   assign pop                = (state == IDLE) && (count != '0);
   assign {head_ch, head_code} = fifo_mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= {cmpl_ch_i, cmpl_code_i};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
         if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (FIFO_AW+1)'(1);
            2'b01:   count <= count - (FIFO_AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // A config write landing on the record's channel during UPDATE supersedes the advance.
   assign cfg_hit_rec = cfg_we && (cfg_ch == rec_ch) && (cfg_sel != 2'd3);

   always_ff @(posedge clk) begin
      if (state == UPDATE && !cfg_hit_rec) begin
         if ({1'b0, off_tbl[rec_ch]} + 17'd1 == {1'b0, size_tbl[rec_ch]}) begin
            off_tbl[rec_ch]   <= '0;
            phase_tbl[rec_ch] <= ~phase_tbl[rec_ch];
         end else begin
            off_tbl[rec_ch] <= off_tbl[rec_ch] + 16'd1;
         end
      end
      if (cfg_we) begin
         case (cfg_sel)
            2'd0: base_tbl[cfg_ch][31:0]  <= cfg_data;
            2'd1: base_tbl[cfg_ch][63:32] <= cfg_data;
            2'd2: begin
               size_tbl[cfg_ch]  <= cfg_data[15:0];
               off_tbl[cfg_ch]   <= '0;
               phase_tbl[cfg_ch] <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign slot_addr = base_tbl[head_ch] + ({48'd0, off_tbl[head_ch]} << BEAT_SHIFT);
   assign aw_done   = !m_axi_awvalid || m_axi_awready;
   assign w_done    = !m_axi_wvalid  || m_axi_wready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         m_axi_awvalid <= 1'b0;
         m_axi_wvalid  <= 1'b0;
         m_axi_bready  <= 1'b0;
         err_valid_o   <= 1'b0;
         err_ch_o      <= '0;
         retry         <= '0;
         rec_ch        <= '0;
         rec_code      <= '0;
         rec_phase     <= 1'b0;
         rec_addr      <= '0;
      end else begin
         err_valid_o <= 1'b0;
         case (state)
            IDLE: if (pop) begin
               rec_ch    <= head_ch;
               rec_code  <= head_code;
               rec_phase <= phase_tbl[head_ch];
               rec_addr  <= ADDR_WIDTH'(slot_addr);
               retry     <= '0;
               if (size_tbl[head_ch] == 16'd0) begin
                  err_valid_o <= 1'b1;
                  err_ch_o    <= head_ch;
               end else begin
                  m_axi_awvalid <= 1'b1;
                  m_axi_wvalid  <= 1'b1;
                  state         <= ISSUE;
               end
            end
            ISSUE: begin
               if (m_axi_awready) m_axi_awvalid <= 1'b0;
               if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
               if (aw_done && w_done) begin
                  m_axi_bready <= 1'b1;
                  state        <= WAIT_B;
               end
            end
            WAIT_B: if (m_axi_bvalid) begin
               m_axi_bready <= 1'b0;
               if (m_axi_bresp == 2'b00) begin
                  state <= UPDATE;
               end else if (retry < RTY_W'(MAX_RETRY)) begin
                  retry         <= retry + RTY_W'(1);
                  m_axi_awvalid <= 1'b1;
                  m_axi_wvalid  <= 1'b1;
                  state         <= ISSUE;
               end else begin
                  err_valid_o <= 1'b1;
                  err_ch_o    <= rec_ch;
                  retry       <= '0;
                  state       <= IDLE;
               end
            end
            UPDATE: begin
               retry <= '0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign m_axi_awid    = '0;
   assign m_axi_awaddr  = rec_addr;
   assign m_axi_awlen   = 8'd0;
   assign m_axi_awsize  = 3'(BEAT_SHIFT);
   assign m_axi_awburst = 2'b01;
   assign m_axi_awcache = 4'd3;
   assign m_axi_awlock  = 1'b0;
   assign m_axi_awprot  = 3'd0;
   assign m_axi_awqos   = 4'd0;
   assign m_axi_awuser  = AWUSER_WIDTH'(rec_ch);
   assign m_axi_wdata   = DATA_WIDTH'({rec_phase, rec_code});
   assign m_axi_wstrb   = '1;
   assign m_axi_wlast   = m_axi_wvalid;

endmodule
`default_nettype wire
